// File: rtl/riscv_test_monitor.sv
// End-of-test checker for riscv-tests: snoops register-file writes and jumps,
// produces sticky pass/fail/timeout verdicts plus jump statistics.
module riscv_test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned PASS_DELAY     = 3,
    parameter logic [4:0]  DONE_REG       = 5'd26,
    parameter logic [4:0]  RESULT_REG     = 5'd27,
    parameter logic [4:0]  TESTNUM_REG    = 5'd3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_reg_we,
    input  logic [4:0]  i_reg_waddr,
    input  logic [31:0] i_reg_wdata,
    input  logic        i_jump_en,
    input  logic [31:0] i_jump_addr,
    input  logic [31:0] i_inst_addr,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_fail,
    output logic        o_timeout,
    output logic [31:0] o_fail_testnum,
    output logic [31:0] o_jump_count,
    output logic [31:0] o_last_jump_src,
    output logic [31:0] o_last_jump_dst
);

    typedef enum logic [2:0] {StRun, StWait, StPass, StFail, StTmo} state_t;

    state_t      r_state;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_result;
    logic [31:0] r_testnum;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_fail_testnum;
    logic [31:0] r_jump_count;
    logic [31:0] r_last_jump_src;
    logic [31:0] r_last_jump_dst;

    logic        w_wr_valid;
    logic        w_wr_done;
    logic        w_wr_result;
    logic        w_wr_testnum;
    logic [31:0] w_eff_result;
    logic [31:0] w_eff_testnum;
    logic        w_active;
    logic        w_timeout_hit;
    logic        w_verdict_hit;

    assign w_wr_valid    = i_reg_we && (i_reg_waddr != 5'd0);
    assign w_wr_done     = w_wr_valid && (i_reg_waddr == DONE_REG) && (i_reg_wdata == 32'd1);
    assign w_wr_result   = w_wr_valid && (i_reg_waddr == RESULT_REG);
    assign w_wr_testnum  = w_wr_valid && (i_reg_waddr == TESTNUM_REG);
    // Same-cycle bypass so a result written on the verdict cycle is honoured.
    assign w_eff_result  = w_wr_result ? i_reg_wdata : r_result;
    assign w_eff_testnum = w_wr_testnum ? i_reg_wdata : r_testnum;
    assign w_active      = (r_state == StRun) || (r_state == StWait);
    assign w_timeout_hit = (r_cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_verdict_hit = (r_state == StWait) && (r_wait_cnt == 32'(PASS_DELAY - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StRun;
            r_wait_cnt      <= 32'd0;
            r_cycle_cnt     <= 32'd0;
            r_result        <= 32'd0;
            r_testnum       <= 32'd0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail          <= 1'b0;
            r_timeout       <= 1'b0;
            r_fail_testnum  <= 32'd0;
            r_jump_count    <= 32'd0;
            r_last_jump_src <= 32'd0;
            r_last_jump_dst <= 32'd0;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_timeout_hit) begin
                        r_state   <= StTmo;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (w_wr_done) begin
                        r_state    <= StWait;
                        r_wait_cnt <= 32'd0;
                    end
                end
                StWait: begin
                    // The delayed verdict takes priority over a coincident timeout.
                    if (w_verdict_hit) begin
                        r_done <= 1'b1;
                        if (w_eff_result == 32'd1) begin
                            r_state <= StPass;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state        <= StFail;
                            r_fail         <= 1'b1;
                            r_fail_testnum <= w_eff_testnum;
                        end
                    end else if (w_timeout_hit) begin
                        r_state   <= StTmo;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                default: ;
            endcase

            if (w_active) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
                if (w_wr_result) r_result <= i_reg_wdata;
                if (w_wr_testnum) r_testnum <= i_reg_wdata;
                if (i_jump_en) begin
                    if (r_jump_count != 32'hFFFF_FFFF) r_jump_count <= r_jump_count + 32'd1;
                    r_last_jump_src <= i_inst_addr;
                    r_last_jump_dst <= i_jump_addr;
                end
            end
        end
    end

    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_fail          = r_fail;
    assign o_timeout       = r_timeout;
    assign o_fail_testnum  = r_fail_testnum;
    assign o_jump_count    = r_jump_count;
    assign o_last_jump_src = r_last_jump_src;
    assign o_last_jump_dst = r_last_jump_dst;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor: directed scenarios plus randomized
// sequences checked against a verdict-level reference model.
module tb_riscv_test_monitor;

    localparam int TMO   = 50;
    localparam int PD    = 3;
    localparam int MAXN  = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [31:0] inst_addr;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_testnum, jump_count, last_jump_src, last_jump_dst;

    int checks = 0;
    int errors = 0;

    // Per-edge stimulus; index e is sampled at the e-th edge after reset.
    logic        s_we    [MAXN];
    logic [4:0]  s_waddr [MAXN];
    logic [31:0] s_wdata [MAXN];
    logic        s_jen   [MAXN];
    logic [31:0] s_jaddr [MAXN];
    logic [31:0] s_iaddr [MAXN];

    logic        e_done, e_pass, e_fail, e_tmo;
    logic [31:0] e_testnum, e_jcnt, e_jsrc, e_jdst;

    riscv_test_monitor #(
        .TIMEOUT_CYCLES(TMO),
        .PASS_DELAY    (PD)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_reg_we       (reg_we),
        .i_reg_waddr    (reg_waddr),
        .i_reg_wdata    (reg_wdata),
        .i_jump_en      (jump_en),
        .i_jump_addr    (jump_addr),
        .i_inst_addr    (inst_addr),
        .o_done         (done),
        .o_pass         (pass),
        .o_fail         (fail),
        .o_timeout      (timeout),
        .o_fail_testnum (fail_testnum),
        .o_jump_count   (jump_count),
        .o_last_jump_src(last_jump_src),
        .o_last_jump_dst(last_jump_dst)
    );

    always #5 clk = ~clk;

    // Reference model: the verdict edge is the earlier of trigger+PD and TMO
    // (verdict wins ties); a trigger at or after TMO never counts.
    function automatic void model(input int n);
        int trig = 0;
        int fin;
        int last;
        logic is_tmo;
        logic [31:0] res = 0;
        logic [31:0] tn = 0;
        e_jcnt = 0;
        e_jsrc = 0;
        e_jdst = 0;
        for (int e = 1; e < TMO; e++)
            if (trig == 0 && s_we[e] && s_waddr[e] == 5'd26 && s_wdata[e] == 32'd1) trig = e;
        is_tmo = !(trig != 0 && trig + PD <= TMO);
        fin    = is_tmo ? TMO : trig + PD;
        last   = (n < fin) ? n : fin;
        for (int e = 1; e <= last; e++) begin
            if (s_we[e] && s_waddr[e] == 5'd27) res = s_wdata[e];
            if (s_we[e] && s_waddr[e] == 5'd3) tn = s_wdata[e];
            if (s_jen[e]) begin
                e_jcnt = e_jcnt + 1;
                e_jsrc = s_iaddr[e];
                e_jdst = s_jaddr[e];
            end
        end
        e_done    = (n >= fin);
        e_pass    = e_done && !is_tmo && res == 32'd1;
        e_fail    = e_done && !is_tmo && res != 32'd1;
        e_tmo     = e_done && is_tmo;
        e_testnum = e_fail ? tn : 32'd0;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            s_we[i] = 0; s_waddr[i] = 0; s_wdata[i] = 0;
            s_jen[i] = 0; s_jaddr[i] = 0; s_iaddr[i] = 0;
        end
    endtask

    task automatic wr(input int e, input logic [4:0] a, input logic [31:0] d);
        s_we[e] = 1; s_waddr[e] = a; s_wdata[e] = d;
    endtask

    task automatic jmp(input int e, input logic [31:0] src, input logic [31:0] dst);
        s_jen[e] = 1; s_iaddr[e] = src; s_jaddr[e] = dst;
    endtask

    task automatic idle();
        reg_we = 0; reg_waddr = 0; reg_wdata = 0;
        jump_en = 0; jump_addr = 0; inst_addr = 0;
    endtask

    task automatic step(input int e);
        reg_we = s_we[e]; reg_waddr = s_waddr[e]; reg_wdata = s_wdata[e];
        jump_en = s_jen[e]; jump_addr = s_jaddr[e]; inst_addr = s_iaddr[e];
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({done, pass, fail, timeout} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {done, pass, fail, timeout});
        end
        checks++;
        if ({fail_testnum, jump_count, last_jump_src, last_jump_dst} !== 128'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h want all zero",
                     fail_testnum, jump_count, last_jump_src, last_jump_dst);
        end
    endtask

    task automatic test_pass();
        logic d5 = 1'b0, d6 = 1'b0;
        do_reset();
        clear_stim();
        wr(1, 27, 1); wr(2, 3, 5); wr(3, 26, 1);
        for (int e = 1; e <= 106; e++) begin
            step(e);
            model(e);
            if (e == 5) d5 = done;
            if (e == 6) d6 = done;
            checks++;
            if ({done, pass, fail, timeout} !== {e_done, e_pass, e_fail, e_tmo}) begin
                errors++;
                $display("FAIL pass_flags e=%0d: got %b want %b", e,
                         {done, pass, fail, timeout}, {e_done, e_pass, e_fail, e_tmo});
            end
        end
        checks++;
        if ({d5, d6} !== 2'b01) begin
            errors++;
            $display("FAIL pass_latency: done at edges 5,6 got %b want 01", {d5, d6});
        end
        checks++;
        if ({done, pass, fail, timeout, fail_testnum} !== {4'b1100, 32'd0}) begin
            errors++;
            $display("FAIL pass_hold: got %b tn=%0d want 1100 tn=0",
                     {done, pass, fail, timeout}, fail_testnum);
        end
    endtask

    task automatic test_fail();
        do_reset();
        clear_stim();
        wr(1, 3, 7); wr(2, 27, 0); wr(3, 26, 1); wr(8, 27, 1);
        for (int e = 1; e <= 12; e++) step(e);
        model(12);
        checks++;
        if ({done, pass, fail, timeout} !== 4'b1010 || e_fail !== 1'b1) begin
            errors++;
            $display("FAIL fail_flags: got %b want 1010", {done, pass, fail, timeout});
        end
        checks++;
        if (fail_testnum !== 32'd7) begin
            errors++;
            $display("FAIL fail_testnum: got %0d want 7", fail_testnum);
        end
    endtask

    task automatic test_bypass();
        for (int late = 0; late < 2; late++) begin
            do_reset();
            clear_stim();
            wr(1, 26, 1);
            wr(4 + late, 27, 1);
            for (int e = 1; e <= 8; e++) step(e);
            model(8);
            checks++;
            if ({done, pass, fail, timeout} !== {e_done, e_pass, e_fail, e_tmo} ||
                {pass, fail} !== (late == 0 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL bypass late=%0d: got %b want %b", late,
                         {done, pass, fail, timeout}, {e_done, e_pass, e_fail, e_tmo});
            end
        end
    endtask

    task automatic test_timeout();
        int trig_e [4] = '{0, 47, 48, 50};
        for (int k = 0; k < 4; k++) begin
            logic d49 = 1'b0;
            do_reset();
            clear_stim();
            wr(10, 27, 1);
            if (trig_e[k] != 0) wr(trig_e[k], 26, 1);
            for (int e = 1; e <= 52; e++) begin
                step(e);
                if (e == 49) d49 = done;
            end
            model(52);
            checks++;
            if (d49 !== 1'b0) begin
                errors++;
                $display("FAIL tmo_early k=%0d: done at edge 49 got %b want 0", k, d49);
            end
            checks++;
            if ({done, pass, fail, timeout} !== {e_done, e_pass, e_fail, e_tmo} ||
                timeout !== (k != 1)) begin
                errors++;
                $display("FAIL tmo_verdict k=%0d: got %b want %b", k,
                         {done, pass, fail, timeout}, {e_done, e_pass, e_fail, e_tmo});
            end
        end
    endtask

    task automatic test_jumps();
        do_reset();
        clear_stim();
        jmp(1, 32'h10, 32'h20); jmp(2, 32'h30, 32'h44);
        jmp(3, 32'h88, 32'h1c); jmp(4, 32'h100, 32'h40);
        wr(5, 0, 1); wr(6, 0, 1);
        wr(7, 26, 1);
        jmp(12, 32'hdead, 32'hbeef);
        for (int e = 1; e <= 6; e++) step(e);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL x0_ignored: done got %b want 0", done);
        end
        for (int e = 7; e <= 14; e++) step(e);
        model(14);
        checks++;
        if ({jump_count, last_jump_src, last_jump_dst} !== {32'd4, 32'h100, 32'h40} ||
            {jump_count, last_jump_src, last_jump_dst} !== {e_jcnt, e_jsrc, e_jdst}) begin
            errors++;
            $display("FAIL jumps: got %0d %h %h want 4 00000100 00000040",
                     jump_count, last_jump_src, last_jump_dst);
        end
        checks++;
        if ({done, pass, fail, timeout} !== 4'b1010) begin
            errors++;
            $display("FAIL jumps_verdict: got %b want 1010", {done, pass, fail, timeout});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_stim();
        wr(1, 3, 9); jmp(1, 32'h4, 32'h8); wr(2, 26, 1);
        for (int e = 1; e <= 3; e++) step(e);
        do_reset();
        checks++;
        if ({done, pass, fail, timeout, fail_testnum, jump_count, last_jump_src,
             last_jump_dst} !== 132'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b %h %h %h %h", {done, pass, fail, timeout},
                     fail_testnum, jump_count, last_jump_src, last_jump_dst);
        end
        clear_stim();
        wr(1, 27, 1); wr(2, 26, 1);
        for (int e = 1; e <= 6; e++) step(e);
        model(6);
        checks++;
        if ({done, pass, fail, timeout} !== 4'b1100 || e_pass !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pass: got %b want 1100", {done, pass, fail, timeout});
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int gate = $urandom_range(1, 55);
            do_reset();
            clear_stim();
            for (int e = 1; e <= 60; e++) begin
                if ($urandom_range(0, 9) < 4) begin
                    logic [4:0] a;
                    logic [31:0] d;
                    case ($urandom_range(0, 5))
                        0: a = 0;
                        1: a = 3;
                        2, 5: a = 26;
                        3: a = 27;
                        default: a = 5'($urandom);
                    endcase
                    if (a == 26 && e < gate) a = 27;
                    case ($urandom_range(0, 3))
                        0: d = 0;
                        3: d = $urandom;
                        default: d = 1;
                    endcase
                    wr(e, a, d);
                end
                if ($urandom_range(0, 9) < 3) jmp(e, $urandom, $urandom);
            end
            for (int e = 1; e <= 60; e++) begin
                step(e);
                model(e);
                checks++;
                if ({done, pass, fail, timeout} !== {e_done, e_pass, e_fail, e_tmo}) begin
                    errors++;
                    $display("FAIL rand_flags it=%0d e=%0d: got %b want %b", it, e,
                             {done, pass, fail, timeout}, {e_done, e_pass, e_fail, e_tmo});
                end
            end
            checks++;
            if ({fail_testnum, jump_count, last_jump_src, last_jump_dst} !==
                {e_testnum, e_jcnt, e_jsrc, e_jdst}) begin
                errors++;
                $display("FAIL rand_regs it=%0d: got %h %h %h %h want %h %h %h %h", it,
                         fail_testnum, jump_count, last_jump_src, last_jump_dst,
                         e_testnum, e_jcnt, e_jsrc, e_jdst);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_pass();
        test_fail();
        test_bypass();
        test_timeout();
        test_jumps();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable end-of-test checker that sits downstream of the riscv core and snoops its register-file write port and jump control.
- Applies the riscv-tests completion convention: x26 is written 1 at test end, x27 holds the result (1 = pass), and x3 holds the test number.
- Produces sticky pass/fail/timeout verdicts plus jump statistics, so simulation benches and FPGA builds share one checker instead of hierarchical peeks.

Parameters:
- TIMEOUT_CYCLES, 25000, cycles after reset before timeout is declared (must be >= 2).
- PASS_DELAY, 3, cycles between the x26==1 write and verdict evaluation (>= 1).
- DONE_REG, 26, register index whose write of 1 signals test end.
- RESULT_REG, 27, register index holding the result; value 1 means pass.
- TESTNUM_REG, 3, register index holding the current test number.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- reg_we  in  1  register-file write enable
- reg_waddr  in  5  register-file write index
- reg_wdata  in  32  register-file write data
- jump_en  in  1  jump/branch taken, execute stage
- jump_addr  in  32  jump target
- inst_addr  in  32  PC of the instruction in execute
- done  out  1  verdict reached (pass, fail or timeout); sticky
- pass  out  1  test passed; sticky
- fail  out  1  test failed; sticky
- timeout  out  1  TIMEOUT_CYCLES elapsed without completion; sticky
- fail_testnum  out  32  testnum shadow latched at verdict
- jump_count  out  32  taken jumps observed, saturating
- last_jump_src  out  32  inst_addr of most recent jump
- last_jump_dst  out  32  jump_addr of most recent jump

Behaviour:
- All outputs, shadows, counters and state are 0 after any clock edge with rst=1. Reset mid-test aborts and returns to RUN with everything cleared.
- Shadows for testnum and result update on reg_we with a matching reg_waddr. Writes with reg_waddr=0 are ignored.
- Shadows update in RUN and WAIT only and freeze in terminal states.
- Bypass: eff_result = reg_wdata if a RESULT_REG write occurs this cycle, else the shadow. eff_testnum is defined the same way.
- FSM states: RUN, WAIT, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal; only rst leaves them.
- RUN -> WAIT when reg_we, reg_waddr==DONE_REG and reg_wdata==1. wait_cnt loads 0 on entry.
- A DONE_REG write with any other value is ignored.
- WAIT: wait_cnt increments each cycle. When wait_cnt==PASS_DELAY-1:
  - go to PASS if eff_result==1, else FAIL;
  - latch fail_testnum=eff_testnum on FAIL only (it stays 0 on PASS).
- done and pass/fail rise at the edge PASS_DELAY cycles after the edge that entered WAIT.
- Further DONE_REG writes during WAIT do not restart wait_cnt.
- cycle_cnt increments every cycle in RUN/WAIT. At cycle_cnt==TIMEOUT_CYCLES-1 the FSM goes to TMO (done=1, timeout=1, pass=fail=0).
- If the timeout and the WAIT verdict fall on the same cycle, the verdict wins and TMO is not entered.
- If the timeout cycle coincides with a RUN->WAIT trigger, TMO wins.
- Exactly one of pass/fail/timeout is 1 whenever done=1.
- Jumps: in RUN/WAIT, each jump_en cycle does the following:
  - jump_count increments, saturating at 0xFFFFFFFF;
  - last_jump_src<=inst_addr;
  - last_jump_dst<=jump_addr.
- Jump outputs freeze in terminal states. Each output is a direct register, with no combinational path from input to output.

Test Plan:
- Write x27=1, x3=5, then x26=1 -> after 3 cycles done=1, pass=1, fail=0, fail_testnum=0; outputs hold for 100 more cycles.
- Write x3=7, x27=0, then x26=1 -> done=1, fail=1, fail_testnum=7. A later x27=1 write leaves the outputs unchanged.
- x26=1 followed by x27=1 written exactly on the verdict cycle -> pass=1 (bypass). Written one cycle after the verdict -> fail=1.
- With TIMEOUT_CYCLES=50, no writes -> at the 50th cycle after reset done=1, timeout=1. Repeat with the x26=1 trigger placed so the verdict lands on the same cycle -> pass/fail wins, timeout=0.
- Pulse jump_en 4 times with (inst_addr, jump_addr) ending at (0x100, 0x40) -> jump_count=4, last_jump_src=0x100, last_jump_dst=0x40. A writes-to-x0 check (x0 writes ignored) must also be covered.
- Assert rst during WAIT -> next cycle all outputs 0, FSM in RUN; a fresh x27=1, x26=1 sequence then passes normally.
